// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op codes and divider depth.
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MUL   = 4'd7,
    OP_MADD  = 4'd8,
    OP_MADDU = 4'd9,
    OP_MSUB  = 4'd10,
    OP_MSUBU = 4'd11
  } op_e;

  localparam int DIV_ITERS = 32;

endpackage

// File: rtl/muldiv_divider.sv
// Restoring radix-2 divider on unsigned magnitudes; one quotient bit per cycle.
// done/quotient/remainder present the final step combinationally so the parent can commit on that edge.
module muldiv_divider
  import muldiv_pkg::*;
(
  input  logic        Clk,
  input  logic        Clr,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        running_r;
  logic [4:0]  cnt_r;
  logic [31:0] q_r;
  logic [31:0] rem_r;
  logic [31:0] dvs_r;
  logic [32:0] shifted_s;
  logic [32:0] diff_s;
  logic [31:0] next_q_s;
  logic [31:0] next_rem_s;

  // One restoring step: trial-subtract divisor from the shifted partial remainder.
  always_comb begin
    shifted_s = {rem_r, q_r[31]};
    diff_s    = shifted_s - {1'b0, dvs_r};
    if (diff_s[32] == 1'b0) begin
      next_rem_s = diff_s[31:0];
      next_q_s   = {q_r[30:0], 1'b1};
    end else begin
      next_rem_s = shifted_s[31:0];
      next_q_s   = {q_r[30:0], 1'b0};
    end
  end

  assign done      = running_r && (cnt_r == 5'(DIV_ITERS - 1));
  assign quotient  = next_q_s;
  assign remainder = next_rem_s;

  // Iteration state: load on start, step while running, stop after the last bit.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      running_r <= 1'b0;
      cnt_r     <= 5'd0;
      q_r       <= 32'd0;
      rem_r     <= 32'd0;
      dvs_r     <= 32'd0;
    end else if (start) begin
      running_r <= 1'b1;
      cnt_r     <= 5'd0;
      q_r       <= dividend;
      rem_r     <= 32'd0;
      dvs_r     <= divisor;
    end else if (running_r) begin
      q_r   <= next_q_s;
      rem_r <= next_rem_s;
      if (done) begin
        running_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r + 5'd1;
      end
    end else begin
      running_r <= running_r;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Define MULDIV_ACCUM_EN to enable
// the MADD/MADDU/MSUB/MSUBU accumulate ops; otherwise ops 8..11 behave as NONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [3:0]  Op,
  input  logic [31:0] XALU_A,
  input  logic [31:0] XALU_B,
  input  logic        Intreq,
  output logic [31:0] XALU_HI,
  output logic [31:0] XALU_LO,
  output logic        XALU_Busy,
  output logic        mul_ok
);

  logic [31:0] hi_r, lo_r, a_r, b_r;
  logic        busy_r, mul_ok_r;
  logic [3:0]  cnt_r;
  op_e         op_r;
  op_e         op_s;
  logic        valid_s, is_mul_s, is_div_s, start_s;
  logic        mul_done_s, div_done_s, done_s;
  logic        div_start_s, a_neg_s, b_neg_s;
  logic [31:0] div_a_s, div_b_s, quo_s, rem_s;
  logic        signed_s;
  logic [63:0] ext_a_s, ext_b_s, prod_s;
  logic [31:0] res_hi_s, res_lo_s;

  assign op_s = op_e'(Op);

  // Decode the incoming op into start class.
  always_comb begin
    valid_s  = 1'b0;
    is_mul_s = 1'b0;
    is_div_s = 1'b0;
    case (op_s)
      OP_MULT, OP_MULTU, OP_MUL: begin valid_s = 1'b1; is_mul_s = 1'b1; end
      OP_DIV, OP_DIVU:           begin valid_s = 1'b1; is_div_s = 1'b1; end
      OP_MTHI, OP_MTLO:          valid_s = 1'b1;
`ifdef MULDIV_ACCUM_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin valid_s = 1'b1; is_mul_s = 1'b1; end
`endif
      default:                   valid_s = 1'b0;
    endcase
  end

  assign start_s     = !busy_r && !Intreq && valid_s;
  assign div_start_s = start_s && is_div_s;
  assign a_neg_s     = (op_s == OP_DIV) && XALU_A[31];
  assign b_neg_s     = (op_s == OP_DIV) && XALU_B[31];
  assign div_a_s     = a_neg_s ? (32'd0 - XALU_A) : XALU_A;
  assign div_b_s     = b_neg_s ? (32'd0 - XALU_B) : XALU_B;

  muldiv_divider u_divider (
    .Clk       (Clk),
    .Clr       (Clr),
    .start     (div_start_s),
    .dividend  (div_a_s),
    .divisor   (div_b_s),
    .done      (div_done_s),
    .quotient  (quo_s),
    .remainder (rem_s)
  );

  assign mul_done_s = busy_r && (op_r != OP_DIV) && (op_r != OP_DIVU) && (cnt_r == 4'd0);
  assign done_s     = mul_done_s || (busy_r && div_done_s);

  // Product of the latched operands, sign- or zero-extended by op.
  always_comb begin
    case (op_r)
      OP_MULT, OP_MUL, OP_MADD, OP_MSUB: signed_s = 1'b1;
      default:                           signed_s = 1'b0;
    endcase
    ext_a_s = signed_s ? {{32{a_r[31]}}, a_r} : {32'd0, a_r};
    ext_b_s = signed_s ? {{32{b_r[31]}}, b_r} : {32'd0, b_r};
    prod_s  = ext_a_s * ext_b_s;
  end

  // Completion result, including signed fix-up and divide special cases.
  always_comb begin
    res_hi_s = hi_r;
    res_lo_s = lo_r;
    case (op_r)
      OP_MULT, OP_MULTU, OP_MUL: {res_hi_s, res_lo_s} = prod_s;
`ifdef MULDIV_ACCUM_EN
      OP_MADD, OP_MADDU: {res_hi_s, res_lo_s} = {hi_r, lo_r} + prod_s;
      OP_MSUB, OP_MSUBU: {res_hi_s, res_lo_s} = {hi_r, lo_r} - prod_s;
`endif
      OP_DIV: begin
        if (b_r == 32'd0) begin
          res_lo_s = 32'hFFFF_FFFF;
          res_hi_s = a_r;
        end else if ((a_r == 32'h8000_0000) && (b_r == 32'hFFFF_FFFF)) begin
          res_lo_s = 32'h8000_0000;
          res_hi_s = 32'd0;
        end else begin
          res_lo_s = (a_r[31] ^ b_r[31]) ? (32'd0 - quo_s) : quo_s;
          res_hi_s = a_r[31] ? (32'd0 - rem_s) : rem_s;
        end
      end
      OP_DIVU: begin
        if (b_r == 32'd0) begin
          res_lo_s = 32'hFFFF_FFFF;
          res_hi_s = a_r;
        end else begin
          res_lo_s = quo_s;
          res_hi_s = rem_s;
        end
      end
      default: begin
        res_hi_s = hi_r;
        res_lo_s = lo_r;
      end
    endcase
  end

  // Control state: busy flag, latency counter, latched op and operands.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      busy_r <= 1'b0;
      cnt_r  <= 4'd0;
      op_r   <= OP_NONE;
      a_r    <= 32'd0;
      b_r    <= 32'd0;
    end else if (start_s && (is_mul_s || is_div_s)) begin
      busy_r <= 1'b1;
      cnt_r  <= 4'(MUL_LAT - 1);
      op_r   <= op_s;
      a_r    <= XALU_A;
      b_r    <= XALU_B;
    end else if (done_s) begin
      busy_r <= 1'b0;
    end else if (busy_r && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      busy_r <= busy_r;
    end
  end

  // Architectural HI/LO and the MUL-complete flag.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      mul_ok_r <= 1'b0;
    end else if (start_s) begin
      mul_ok_r <= 1'b0;
      if (op_s == OP_MTHI) begin
        hi_r <= XALU_A;
      end else if (op_s == OP_MTLO) begin
        lo_r <= XALU_A;
      end else begin
        hi_r <= hi_r;
      end
    end else if (done_s) begin
      hi_r     <= res_hi_s;
      lo_r     <= res_lo_s;
      mul_ok_r <= (op_r == OP_MUL);
    end else begin
      hi_r <= hi_r;
    end
  end

  assign XALU_HI   = hi_r;
  assign XALU_LO   = lo_r;
  assign XALU_Busy = busy_r;
  assign mul_ok    = mul_ok_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (default MUL_LAT=4).
module tb_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Clr;
  logic [3:0]  Op;
  logic [31:0] XALU_A, XALU_B;
  logic        Intreq;
  logic [31:0] XALU_HI, XALU_LO;
  logic        XALU_Busy, mul_ok;
  int          check_cnt = 0;
  int          err_cnt = 0;
  int          n;

  muldiv_unit #(.MUL_LAT(4)) dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .Op        (Op),
    .XALU_A    (XALU_A),
    .XALU_B    (XALU_B),
    .Intreq    (Intreq),
    .XALU_HI   (XALU_HI),
    .XALU_LO   (XALU_LO),
    .XALU_Busy (XALU_Busy),
    .mul_ok    (mul_ok)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ir);
    Op = op; XALU_A = a; XALU_B = b; Intreq = ir;
    step();
    Op = 4'd0; Intreq = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (XALU_Busy && cycles < 100) begin
      cycles++;
      step();
    end
  endtask

  initial begin
    Clr = 1'b1; Op = 4'd0; XALU_A = 32'd0; XALU_B = 32'd0; Intreq = 1'b0;
    step(); step();
    Clr = 1'b0;
    step();
    check("rst_hi", XALU_HI, 32'd0);
    check("rst_lo", XALU_LO, 32'd0);
    check("rst_busy", 32'(XALU_Busy), 32'd0);
    check("rst_mulok", 32'(mul_ok), 32'd0);

    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_busy_hold_hi", XALU_HI, 32'd0);
    wait_idle(n);
    check("mult_lat", 32'(n), 32'd4);
    check("mult_hi", XALU_HI, 32'hFFFF_FFFF);
    check("mult_lo", XALU_LO, 32'hFFFF_FFFA);

    issue(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle(n);
    check("multu_hi", XALU_HI, 32'h0000_0002);
    check("multu_lo", XALU_LO, 32'hFFFF_FFFA);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_busy_hold_lo", XALU_LO, 32'hFFFF_FFFA);
    wait_idle(n);
    check("div_lat", 32'(n), 32'd32);
    check("div_lo", XALU_LO, 32'hFFFF_FFFD);
    check("div_hi", XALU_HI, 32'hFFFF_FFFF);

    issue(4'd4, 32'd5, 32'd0, 1'b0);
    wait_idle(n);
    check("divu0_lo", XALU_LO, 32'hFFFF_FFFF);
    check("divu0_hi", XALU_HI, 32'd5);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    check("divovf_lo", XALU_LO, 32'h8000_0000);
    check("divovf_hi", XALU_HI, 32'd0);

    issue(4'd4, 32'd100, 32'd7, 1'b0);
    wait_idle(n);
    check("divu_lo", XALU_LO, 32'd14);
    check("divu_hi", XALU_HI, 32'd2);

    issue(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
    wait_idle(n);
    check("divneg_lo", XALU_LO, 32'hFFFF_FFFD);
    check("divneg_hi", XALU_HI, 32'd1);

    issue(4'd7, 32'd6, 32'd7, 1'b1);
    check("intreq_busy", 32'(XALU_Busy), 32'd0);
    check("intreq_mulok", 32'(mul_ok), 32'd0);
    check("intreq_lo", XALU_LO, 32'hFFFF_FFFD);

    issue(4'd7, 32'd6, 32'd7, 1'b0);
    wait_idle(n);
    check("mul_lat", 32'(n), 32'd4);
    check("mul_lo", XALU_LO, 32'd42);
    check("mul_hi", XALU_HI, 32'd0);
    check("mul_ok_set", 32'(mul_ok), 32'd1);

`ifdef MULDIV_ACCUM_EN
    issue(4'd8, 32'd2, 32'd3, 1'b0);
    wait_idle(n);
    check("madd_lo", XALU_LO, 32'd48);
    check("madd_mulok", 32'(mul_ok), 32'd0);
`else
    issue(4'd8, 32'd2, 32'd3, 1'b0);
    check("op8_busy", 32'(XALU_Busy), 32'd0);
    check("op8_lo", XALU_LO, 32'd42);
    step(); step();
    check("mul_ok_held", 32'(mul_ok), 32'd1);
`endif

    issue(4'd5, 32'h0000_ABCD, 32'd0, 1'b0);
    check("mthi_hi", XALU_HI, 32'h0000_ABCD);
    check("mthi_busy", 32'(XALU_Busy), 32'd0);
    check("mthi_mulok", 32'(mul_ok), 32'd0);

    issue(4'd6, 32'h0000_1234, 32'd0, 1'b0);
    check("mtlo_lo", XALU_LO, 32'h0000_1234);
    check("mtlo_busy", 32'(XALU_Busy), 32'd0);

    issue(4'd3, 32'd100, 32'd3, 1'b0);
    step(); step(); step(); step(); step();
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    check("clr_busy", 32'(XALU_Busy), 32'd0);
    check("clr_hi", XALU_HI, 32'd0);
    check("clr_lo", XALU_LO, 32'd0);
    for (int i = 0; i < 40; i++) step();
    check("clr_abort_lo", XALU_LO, 32'd0);
    check("clr_abort_busy", 32'(XALU_Busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
